// File: rtl/mult_wddl_pkg.sv
// rtl/mult_wddl_pkg.sv - shared constants and state encoding for the WDDL shift-add multiplier
package mult_wddl_pkg;

    localparam int WIDTH  = 13;
    localparam int PROD_W = 2 * WIDTH;

    // 2^13-1; operand 0x1FFF is the alternate encoding of zero, folded downstream
    localparam logic [WIDTH-1:0] MOD      = 13'h1FFF;
    localparam logic [3:0]       CNT_LAST = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mult_13x13_seq_wddl_if.sv
// rtl/mult_13x13_seq_wddl_if.sv - operand/product handshake bundle for mult_13x13_seq_wddl
interface mult_13x13_seq_wddl_if;
    import mult_wddl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              out_valid;
    logic [PROD_W-1:0] naive;
    logic [PROD_W-1:0] naive_n;
    logic              busy;

    modport master (
        output in_valid, a, b,
        input  in_ready, out_valid, naive, naive_n, busy
    );

    modport slave (
        input  in_valid, a, b,
        output in_ready, out_valid, naive, naive_n, busy
    );

endinterface

// File: rtl/adder_26_bit_wddl.sv
// rtl/adder_26_bit_wddl.sv - dual-rail 26-bit adder producing sum and complement rail
module adder_26_bit_wddl
    import mult_wddl_pkg::*;
(
    input  logic [PROD_W-1:0] A,
    input  logic [PROD_W-1:0] B,
    output logic [PROD_W:0]   C,
    output logic [PROD_W:0]   C_n
);

    assign C   = {1'b0, A} + {1'b0, B};
    assign C_n = ~C;

endmodule

// File: rtl/mult_13x13_seq_wddl.sv
// rtl/mult_13x13_seq_wddl.sv - sequential 13x13 shift-add multiplier, dual-rail product; option MULT_PRECHARGE_EN
module mult_13x13_seq_wddl
    import mult_wddl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mult_13x13_seq_wddl_if.slave  bus
);

`ifdef MULT_PRECHARGE_EN
    localparam logic [PROD_W-1:0] ACC_N_IDLE = '0;
    localparam logic [WIDTH-1:0]  A_N_IDLE   = '0;
`else
    localparam logic [PROD_W-1:0] ACC_N_IDLE = '1;
    localparam logic [WIDTH-1:0]  A_N_IDLE   = '1;
`endif

    state_t            state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  a_reg_n;
    logic [WIDTH-1:0]  b_reg;
    logic [3:0]        cnt;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] acc_n;
    logic [PROD_W-1:0] addend;
    logic [PROD_W:0]   sum;
    logic [PROD_W:0]   sum_n;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;

    // A zero addend makes the adder return acc unchanged, so acc always loads sum in BUSY
    always_comb begin
        addend = '0;
        if (b_reg[cnt])
            addend = {{WIDTH{1'b0}}, a_reg} << cnt;
    end

    adder_26_bit_wddl u_adder (
        .A   (acc),
        .B   (addend),
        .C   (sum),
        .C_n (sum_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            acc_n       <= ACC_N_IDLE;
            a_reg       <= '0;
            a_reg_n     <= A_N_IDLE;
            b_reg       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= bus.a;
                        a_reg_n    <= ~bus.a;
                        b_reg      <= bus.b;
                        acc        <= '0;
                        acc_n      <= '1;
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= sum[PROD_W-1:0];
                    acc_n <= sum_n[PROD_W-1:0];
                    if (cnt == CNT_LAST) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
`ifdef MULT_PRECHARGE_EN
                    acc         <= '0;
                    acc_n       <= '0;
`endif
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;

`ifdef MULT_PRECHARGE_EN
    // Both rails sit at 0 outside DONE; gated by the registered out_valid
    assign bus.naive   = out_valid_r ? acc   : '0;
    assign bus.naive_n = out_valid_r ? acc_n : '0;
`else
    assign bus.naive   = acc;
    assign bus.naive_n = acc_n;
`endif

    a_carry_clear: assert property (@(posedge clk) disable iff (rst)
        (state != BUSY) || !sum[PROD_W]);
    a_sum_rails: assert property (@(posedge clk) disable iff (rst)
        sum_n == ~sum);
    a_operand_rails: assert property (@(posedge clk) disable iff (rst)
        (state != BUSY) || (a_reg_n == ~a_reg));

endmodule

// File: tb/tb_mult_13x13_seq_wddl.sv
// tb/tb_mult_13x13_seq_wddl.sv - directed self-checking bench for mult_13x13_seq_wddl
module tb_mult_13x13_seq_wddl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

`ifdef MULT_PRECHARGE_EN
    localparam logic [25:0] IDLE_N = 26'h0000000;
`else
    localparam logic [25:0] IDLE_N = 26'h3FFFFFF;
`endif

    mult_13x13_seq_wddl_if bus ();

    mult_13x13_seq_wddl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [12:0] a, input logic [12:0] b,
                          input logic [25:0] exp);
        int          lat;
        logic [25:0] exp_n;
`ifdef MULT_PRECHARGE_EN
        bit          pre_bad;
        pre_bad = 1'b0;
`endif
        exp_n = ~exp;
        lat   = 0;
        wait_ready(tag);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k;
                break;
            end
`ifdef MULT_PRECHARGE_EN
            if (bus.naive != 26'd0 || bus.naive_n != 26'd0)
                pre_bad = 1'b1;
`endif
        end
        check({tag, " latency"}, lat, 32'd14);
        check({tag, " naive"}, {6'b0, bus.naive}, {6'b0, exp});
        check({tag, " naive_n"}, {6'b0, bus.naive_n}, {6'b0, exp_n});
        @(negedge clk);
        check({tag, " idle in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        check({tag, " idle out_valid"}, {31'b0, bus.out_valid}, 32'd0);
`ifdef MULT_PRECHARGE_EN
        check({tag, " busy rails precharged"}, {31'b0, pre_bad}, 32'd0);
        check({tag, " idle naive precharged"}, {6'b0, bus.naive}, 32'd0);
        check({tag, " idle naive_n precharged"}, {6'b0, bus.naive_n}, 32'd0);
`else
        check({tag, " idle naive hold"}, {6'b0, bus.naive}, {6'b0, exp});
`endif
    endtask

    initial begin
        int first;
        int second;
        int low;
        int pulses;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset naive", {6'b0, bus.naive}, 32'd0);
        check("reset naive_n", {6'b0, bus.naive_n}, {6'b0, IDLE_N});

        run_op("3x5", 13'd3, 13'd5, 26'h000000F);
        run_op("max", 13'h1FFF, 13'h1FFF, 26'h3FFC001);
        run_op("0x1234", 13'h0000, 13'h1234, 26'h0000000);
        run_op("1xmax", 13'h0001, 13'h1FFF, 26'h0001FFF);
        run_op("maxx1", 13'h1FFF, 13'h0001, 26'h0001FFF);
        run_op("abcx1234", 13'h0ABC, 13'h1234, 26'h0C36630);
        run_op("1000sq", 13'h1000, 13'h1000, 26'h1000000);
        run_op("maxx1000", 13'h1FFF, 13'h1000, 26'h1FFF000);
        run_op("100sq", 13'h0100, 13'h0100, 26'h0010000);

        // in_valid held high: one accept per 15-cycle slot
        wait_ready("held");
        bus.a        = 13'h1000;
        bus.b        = 13'd2;
        bus.in_valid = 1'b1;
        @(posedge clk);
        first  = 0;
        second = 0;
        low    = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 14 && !bus.in_ready)
                low++;
            if (k == 15)
                check("held reaccept ready", {31'b0, bus.in_ready}, 32'd1);
            if (bus.out_valid) begin
                check("held naive", {6'b0, bus.naive}, 32'h0002000);
                if (first == 0) begin
                    first = k;
                end else if (second == 0) begin
                    second       = k;
                    bus.in_valid = 1'b0;
                end else begin
                    check("held extra pulse", k, 32'd0);
                end
            end
        end
        bus.in_valid = 1'b0;
        check("held first pulse", first, 32'd14);
        check("held second pulse", second, 32'd29);
        check("held in_ready low", low, 32'd14);

        // reset in the 6th BUSY cycle, with in_valid asserted alongside rst
        wait_ready("rst_mid");
        bus.a        = 13'h0ABC;
        bus.b        = 13'h1234;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_mid busy before", {31'b0, bus.busy}, 32'd1);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_mid in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_mid busy", {31'b0, bus.busy}, 32'd0);
        check("rst_mid naive", {6'b0, bus.naive}, 32'd0);
        check("rst_mid naive_n", {6'b0, bus.naive_n}, {6'b0, IDLE_N});
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid)
                pulses++;
        end
        check("rst_mid no out_valid", pulses, 32'd0);
        check("rst_mid still idle", {31'b0, bus.busy}, 32'd0);

        run_op("7x9", 13'd7, 13'd9, 26'h000003F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
